if_bus_if: RTL and testbench
============================

Name: if_bus_if

Overview:
- Instruction-fetch bus interface. It is the producer side of the IF/ID pipeline register's instruction input.
- Takes the current fetch address (IF-stage PC) and runs a request/grant/strobe/ready transaction on the shared bus.
- Returns the fetched word as `insn` to the IF/ID register.
- Asserts `busy` to pipeline control so the fetch stage stalls until the word is available. Honours pipeline `stall`/`flush`.

Parameters:
- ADDR_W, 30, word-address width (WordAddrBus)
- DATA_W, 32, data width (WordDataBus)
- NOP_INSN, 32'h0000_0000, ISA NOP encoding returned on flush/abort
- TIMEOUT_CYC, 255, max ACCESS cycles before abort (IF_BUS_TIMEOUT_EN only); counter is 8 bits

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- stall  in  1  pipeline stall; hold delivered word
- flush  in  1  pipeline flush; discard fetch
- addr  in  ADDR_W  fetch word address (IF-stage PC)
- insn  out  DATA_W  fetched instruction to IF/ID register
- busy  out  1  fetch not complete; stall request to pipeline control
- bus_req  out  1  bus request to arbiter
- bus_grnt  in  1  bus grant
- bus_as_  out  1  address strobe, active-low
- bus_addr  out  ADDR_W  bus address
- bus_rdy_  in  1  read ready, active-low
- bus_rd_data  in  DATA_W  bus read data
- bus_err  out  1  timeout abort pulse (only with IF_BUS_TIMEOUT_EN)

Behaviour:
- Reset/clocking:
  - One clock; reset is asynchronous and active-low.
  - During reset: state=IDLE, bus_req=0, bus_as_=1, bus_addr=0, rd_buf=NOP_INSN, bus_err=0.
- Output timing: bus_req, bus_as_, bus_addr and bus_err are registered. insn and busy are combinational from state and inputs.
- IDLE:
  - flush=1: busy=0, insn=NOP_INSN, stay IDLE.
  - Otherwise: busy=1, insn=NOP_INSN; at edge bus_req<=1, go REQ.
- REQ:
  - busy=1, insn=NOP_INSN.
  - flush=1: bus_req<=0, go IDLE (abort; no strobe issued). busy=0 this cycle.
  - Else bus_grnt=1: bus_as_<=0, bus_addr<=addr, go ACCESS.
  - Else stay in REQ.
- ACCESS:
  - bus_as_<=1 at the first edge in ACCESS (one-cycle strobe).
  - While bus_rdy_=1: busy=1, insn=NOP_INSN.
  - On bus_rdy_=0: busy=0 and bus_req<=0.
    - Without flush: insn=bus_rd_data (same cycle) and rd_buf<=bus_rd_data. Next state is WAIT if stall=1, else IDLE.
    - With flush=1: insn=NOP_INSN, next state IDLE, rd_buf unchanged.
  - A flush while bus_rdy_=1 does not abort the transaction. It is remembered in flush_pend, busy stays 1, and the returned data is discarded (insn=NOP_INSN, go IDLE).
- WAIT:
  - busy=0, insn=rd_buf.
  - stall=0 or flush=1: go IDLE. On flush, insn=NOP_INSN in that cycle.
- Latency: with immediate grant and ready, busy is high for 2 cycles and the word appears in the 3rd cycle. The pipeline advances at the end of that cycle.
- addr is sampled only on the REQ→ACCESS edge. Changes in addr after that edge do not affect the current transaction.
- Simultaneous flush and stall: flush wins.
- bus_grnt deasserting during ACCESS is ignored.
- Reset mid-transaction: everything returns to IDLE immediately. The bus is released (bus_req=0, bus_as_=1) asynchronously.

Optional Feature:
- Macro: IF_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with bus_rdy_=1.
  - When the count reaches TIMEOUT_CYC: bus_err<=1 for one cycle, bus_req<=0, insn=NOP_INSN, busy=0 that cycle, go IDLE.
- Undefined: no counter and no bus_err port; ACCESS waits indefinitely for bus_rdy_.

Test Plan:
- Fast fetch: release reset; addr=30'h10, grant in cycle 1, bus_rdy_=0 with data 32'hDEAD_BEEF in cycle 2. Required: busy=1,1,0; bus_as_ low exactly one cycle; bus_addr=30'h10; insn=32'hDEAD_BEEF in cycle 2.
- Grant delay: grant withheld 4 cycles. Required: bus_req stays 1 and bus_as_=1 throughout; strobe asserted only after bus_grnt=1.
- Stall hold: word 32'h1234_5678 returned with stall=1 for 3 cycles. Required: state WAIT, insn=32'h1234_5678, busy=0 for all 3 cycles; IDLE after stall drops.
- Flush in REQ: flush pulsed in REQ. Required: no bus_as_ pulse, bus_req=0 next cycle, insn=NOP_INSN, busy=0.
- Flush in ACCESS: flush pulsed before ready; ready arrives 2 cycles later with 32'hCAFE_0001. Required: busy=1 until ready, insn=NOP_INSN, data discarded, state IDLE.
- Timeout (with IF_BUS_TIMEOUT_EN): bus_rdy_ held high. Required: bus_err pulses once after 255 ACCESS cycles, insn=NOP_INSN, bus_req=0.

Source files
------------

// File: rtl/if_bus_if.sv
// Instruction-fetch bus interface: runs a req/grant/strobe/ready read for the IF-stage PC and hands the word to IF/ID.
// Optional ACCESS timeout with one-cycle bus_err pulse when IF_BUS_TIMEOUT_EN is defined.
module if_bus_if #(
  parameter int unsigned       ADDR_W   = 30,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0000)
`ifdef IF_BUS_TIMEOUT_EN
  ,
  parameter int unsigned       TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] insn,
  output logic              busy,
  output logic              bus_req,
  input  logic              bus_grnt,
  output logic              bus_as_,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rdy_,
  input  logic [DATA_W-1:0] bus_rd_data
`ifdef IF_BUS_TIMEOUT_EN
  ,
  output logic              bus_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  state_e            state_q,      state_d;
  logic              bus_req_q,    bus_req_d;
  logic              bus_as_n_q,   bus_as_n_d;
  logic [ADDR_W-1:0] bus_addr_q,   bus_addr_d;
  logic [DATA_W-1:0] rd_buf_q,     rd_buf_d;
  logic              flush_pend_q, flush_pend_d;

`ifdef IF_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = 8;
  logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
  logic              bus_err_q,    bus_err_d;
`endif

  // State and bus-side registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= ST_IDLE;
      bus_req_q    <= 1'b0;
      bus_as_n_q   <= 1'b1;
      bus_addr_q   <= '0;
      rd_buf_q     <= NOP_INSN;
      flush_pend_q <= 1'b0;
`ifdef IF_BUS_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_as_n_q   <= bus_as_n_d;
      bus_addr_q   <= bus_addr_d;
      rd_buf_q     <= rd_buf_d;
      flush_pend_q <= flush_pend_d;
`ifdef IF_BUS_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  // Next-state, bus-register updates and the combinational pipeline-side outputs.
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_as_n_d   = bus_as_n_q;
    bus_addr_d   = bus_addr_q;
    rd_buf_d     = rd_buf_q;
    flush_pend_d = flush_pend_q;
    insn         = NOP_INSN;
    busy         = 1'b0;
`ifdef IF_BUS_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    bus_err_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          busy      = 1'b1;
          bus_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        if (flush) begin
          bus_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          busy = 1'b1;
          if (bus_grnt) begin
            bus_as_n_d   = 1'b0;
            bus_addr_d   = addr;
            flush_pend_d = 1'b0;
`ifdef IF_BUS_TIMEOUT_EN
            tmo_cnt_d    = '0;
`endif
            state_d      = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        bus_as_n_d = 1'b1;
        if (!bus_rdy_) begin
          bus_req_d    = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = ST_IDLE;
          // A flush seen now or earlier in this access discards the returned word.
          if (!(flush || flush_pend_q)) begin
            insn     = bus_rd_data;
            rd_buf_d = bus_rd_data;
            if (stall) begin
              state_d = ST_WAIT;
            end
          end
        end else begin
`ifdef IF_BUS_TIMEOUT_EN
          if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            bus_err_d    = 1'b1;
            bus_req_d    = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            busy      = 1'b1;
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (flush) begin
              flush_pend_d = 1'b1;
            end
          end
`else
          busy = 1'b1;
          if (flush) begin
            flush_pend_d = 1'b1;
          end
`endif
        end
      end

      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          insn = rd_buf_q;
          if (!stall) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_req  = bus_req_q;
  assign bus_as_  = bus_as_n_q;
  assign bus_addr = bus_addr_q;
`ifdef IF_BUS_TIMEOUT_EN
  assign bus_err  = bus_err_q;
`endif

endmodule

// File: tb/tb_if_bus_if.sv
// Directed bench for if_bus_if: fast fetch, grant delay, stall hold, flushes, async reset, optional timeout.
module tb_if_bus_if;

  logic        clk;
  logic        reset_;
  logic        stall;
  logic        flush;
  logic [29:0] addr;
  logic [31:0] insn;
  logic        busy;
  logic        bus_req;
  logic        bus_grnt;
  logic        bus_as_;
  logic [29:0] bus_addr;
  logic        bus_rdy_;
  logic [31:0] bus_rd_data;
`ifdef IF_BUS_TIMEOUT_EN
  logic        bus_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  if_bus_if dut (
    .clk         (clk),
    .reset_      (reset_),
    .stall       (stall),
    .flush       (flush),
    .addr        (addr),
    .insn        (insn),
    .busy        (busy),
    .bus_req     (bus_req),
    .bus_grnt    (bus_grnt),
    .bus_as_     (bus_as_),
    .bus_addr    (bus_addr),
    .bus_rdy_    (bus_rdy_),
    .bus_rd_data (bus_rd_data)
`ifdef IF_BUS_TIMEOUT_EN
    ,
    .bus_err     (bus_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle: drive inputs just after the edge, then let comb outputs settle.
  task automatic cyc(input logic f, input logic s, input logic g, input logic r,
                     input logic [29:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    flush       = f;
    stall       = s;
    bus_grnt    = g;
    bus_rdy_    = r;
    addr        = a;
    bus_rd_data = d;
    #2;
  endtask

  initial begin
    reset_      = 1'b0;
    flush       = 1'b0;
    stall       = 1'b0;
    bus_grnt    = 1'b0;
    bus_rdy_    = 1'b1;
    addr        = '0;
    bus_rd_data = '0;

    #7;
    check("rst_bus_req",  32'(bus_req),  32'd0);
    check("rst_bus_as_",  32'(bus_as_),  32'd1);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_insn",     insn,          32'h0);
    check("rst_busy",     32'(busy),     32'd1);
`ifdef IF_BUS_TIMEOUT_EN
    check("rst_bus_err",  32'(bus_err),  32'd0);
`endif
    repeat (2) @(posedge clk);

    // Fast fetch: IDLE, REQ with grant, ACCESS with ready.
    @(negedge clk);
    reset_ = 1'b1;
    addr   = 30'h10;
    #1;
    check("ff_busy_c0", 32'(busy), 32'd1);
    check("ff_insn_c0", insn,      32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 30'h10, 32'h0);
    check("ff_busy_c1",   32'(busy),    32'd1);
    check("ff_req_c1",    32'(bus_req), 32'd1);
    check("ff_as_c1",     32'(bus_as_), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 30'h10, 32'hDEAD_BEEF);
    check("ff_as_c2",     32'(bus_as_),  32'd0);
    check("ff_addr_c2",   32'(bus_addr), 32'h10);
    check("ff_busy_c2",   32'(busy),     32'd0);
    check("ff_insn_c2",   insn,          32'hDEAD_BEEF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h10, 32'h0);
    check("ff_as_c3",     32'(bus_as_), 32'd1);
    check("ff_req_c3",    32'(bus_req), 32'd0);
    check("ff_busy_c3",   32'(busy),    32'd1);

    // Grant withheld for 4 cycles in REQ.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h2A, 32'h0);
      check("gd_req",  32'(bus_req), 32'd1);
      check("gd_as_",  32'(bus_as_), 32'd1);
      check("gd_busy", 32'(busy),    32'd1);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 30'h2A, 32'h0);
    check("gd_as_grant_cyc", 32'(bus_as_), 32'd1);
    // addr changes after the sampling edge; grant drop in ACCESS is ignored.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h3F, 32'h0);
    check("gd_as_strobe", 32'(bus_as_),  32'd0);
    check("gd_addr",      32'(bus_addr), 32'h2A);
    check("gd_busy_acc",  32'(busy),     32'd1);
    check("gd_insn_acc",  insn,          32'h0);

    // Stall hold: word returned with stall, then 3 WAIT cycles.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 30'h3F, 32'h1234_5678);
    check("sh_as_end",  32'(bus_as_),  32'd1);
    check("sh_addr",    32'(bus_addr), 32'h2A);
    check("sh_busy_rd", 32'(busy),     32'd0);
    check("sh_insn_rd", insn,          32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 30'h3F, 32'hFFFF_0000);
      check("sh_insn_wait", insn,          32'h1234_5678);
      check("sh_busy_wait", 32'(busy),     32'd0);
      check("sh_req_wait",  32'(bus_req),  32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h3F, 32'h0);
    check("sh_insn_release", insn,      32'h1234_5678);
    check("sh_busy_release", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h3F, 32'h0);
    check("sh_idle_busy", 32'(busy), 32'd1);
    check("sh_idle_insn", insn,      32'h0);

    // Flush in REQ, even with grant present.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 30'h44, 32'h0);
    check("fr_busy", 32'(busy),    32'd0);
    check("fr_insn", insn,         32'h0);
    check("fr_req",  32'(bus_req), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 30'h44, 32'h0);
    check("fr_req_after", 32'(bus_req), 32'd0);
    check("fr_no_strobe", 32'(bus_as_), 32'd1);
    check("fr_idle_busy", 32'(busy),    32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h44, 32'h0);
    check("fr_no_strobe2", 32'(bus_as_), 32'd1);
    check("fr_restart",    32'(busy),    32'd1);

    // Flush in ACCESS before ready; returned data discarded.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 30'h55, 32'h0);
    check("fa_req",  32'(bus_req), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 30'h55, 32'h0);
    check("fa_busy0", 32'(busy),     32'd1);
    check("fa_insn0", insn,          32'h0);
    check("fa_addr",  32'(bus_addr), 32'h55);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h55, 32'h0);
    check("fa_busy1", 32'(busy), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 30'h55, 32'hCAFE_0001);
    check("fa_busy_rdy", 32'(busy), 32'd0);
    check("fa_insn_rdy", insn,      32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h55, 32'h0);
    check("fa_idle_busy", 32'(busy),    32'd1);
    check("fa_idle_req",  32'(bus_req), 32'd0);

    // Flush and stall together at ready: flush wins, no WAIT.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 30'h07, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 30'h07, 32'hAAAA_5555);
    check("fs_busy", 32'(busy), 32'd0);
    check("fs_insn", insn,      32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h07, 32'h0);
    check("fs_idle_busy", 32'(busy), 32'd1);
    check("fs_idle_insn", insn,      32'h0);

    // Flush during WAIT returns NOP that cycle.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 30'h09, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 30'h09, 32'h0BAD_F00D);
    check("fw_insn_rd", insn, 32'h0BAD_F00D);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 30'h09, 32'h0);
    check("fw_insn", insn,      32'h0);
    check("fw_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h09, 32'h0);
    check("fw_idle_busy", 32'(busy), 32'd1);

    // Asynchronous reset mid-access releases the bus without a clock edge.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 30'h0B, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h0B, 32'h0);
    check("ar_as_before",  32'(bus_as_), 32'd0);
    check("ar_req_before", 32'(bus_req), 32'd1);
    reset_ = 1'b0;
    #1;
    check("ar_req",  32'(bus_req),  32'd0);
    check("ar_as_",  32'(bus_as_),  32'd1);
    check("ar_addr", 32'(bus_addr), 32'd0);
    check("ar_busy", 32'(busy),     32'd1);
    @(negedge clk);
    reset_ = 1'b1;

`ifdef IF_BUS_TIMEOUT_EN
    begin
      int abort_cyc;
      abort_cyc = -1;
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 30'h0C, 32'h0);
      for (int k = 0; k < 400; k++) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h0C, 32'h0);
        if (!busy) begin
          abort_cyc = k;
          check("to_insn", insn, 32'h0);
          break;
        end
      end
      check("to_abort_cycle", 32'(abort_cyc), 32'd254);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h0C, 32'h0);
      check("to_err_pulse", 32'(bus_err), 32'd1);
      check("to_req",       32'(bus_req), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 30'h0C, 32'h0);
      check("to_err_clear", 32'(bus_err), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
